breakout_ball: RTL and testbench
================================

BREAKOUT_BALL -- requirements
Module: breakout_ball

Interface
REQ-001 SHALL have parameter W, default 10: coordinate width in bits.
REQ-002 SHALL have parameter X_MIN, default 10: left wall.
REQ-003 SHALL have parameter X_MAX, default 639: right wall.
REQ-004 SHALL have parameter Y_MIN, default 0: top wall.
REQ-005 SHALL have parameter Y_MAX, default 479: bottom, the miss line.
REQ-006 SHALL have parameter SIZE, default 4: ball half-size.
REQ-007 SHALL have parameter PADDLE_Y, default 460: paddle top edge.
REQ-008 SHALL have parameter START_X, default 320: reset X.
REQ-009 SHALL have parameter STEP_INIT, default 1: serve speed in pixels per frame.
REQ-010 SHALL have parameter STEP_MAX, default 4: speed ceiling.
REQ-011 SHALL have parameter HITS_PER_STEP, default 4: paddle hits per speed increment.
REQ-012 SHALL have parameter LOST_FRAMES, default 60: frames held after a miss.
REQ-013 SHALL have port frame_clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-014 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-015 SHALL have port keycode, input, 8 bits: current key; 8'h2C = serve (space), 8'h29 = pause (Esc, held).
REQ-016 SHALL have port paddle_x, input, W bits: paddle centre X.
REQ-017 SHALL have port paddle_hw, input, W bits: paddle half-width.
REQ-018 SHALL have port brick_hit, input, 1 bit: brick collision reported for this frame.
REQ-019 SHALL have port brick_vert, input, 1 bit: valid with brick_hit; 1 = reverse Y, 0 = reverse X.
REQ-020 SHALL have ports BallX and BallY, output, W bits each: ball centre.
REQ-021 SHALL have port BallS, output, W bits: constant SIZE.
REQ-022 SHALL have port ball_state, output, 2 bits: 00 SERVE, 01 PLAY, 10 LOST.
REQ-023 SHALL have port speed, output, 3 bits: current step magnitude.
REQ-024 SHALL have port miss, output, 1 bit: one-frame pulse on entry to LOST.

Function
REQ-025 SHALL store motion as direction bits dx_neg and dy_neg plus the unsigned magnitude speed; SHALL NOT use two's-complement motion registers.
REQ-026 SHALL compute the next position from the direction decided in the same frame, so a bounce takes effect on the frame it is detected.
REQ-027 SHALL compute candidate positions in W+2-bit signed arithmetic so that no underflow or wrap occurs near 0 or near 2^W-1.
REQ-028 SERVE: SHALL set BallX = paddle_x clamped to [X_MIN+SIZE, X_MAX-SIZE] and BallY = PADDLE_Y-SIZE-1 every frame.
REQ-029 SERVE: SHALL move to PLAY with dx_neg=0, dy_neg=1 and speed=STEP_INIT when keycode==8'h2C.
REQ-030 PLAY: SHALL hold all state unchanged for each frame while keycode==8'h29, ignoring brick_hit.
REQ-031 PLAY: SHALL apply a brick_hit reversal to dy_neg (brick_vert=1) or dx_neg (brick_vert=0) first, then step the position by ±speed on each axis.
REQ-032 Left wall: SHALL set BallX=X_MIN+SIZE and dx_neg=0 if moving left and candidate X-SIZE <= X_MIN.
REQ-033 Right wall: SHALL set BallX=X_MAX-SIZE and dx_neg=1 if moving right and candidate X+SIZE >= X_MAX.
REQ-034 Top wall: SHALL set BallY=Y_MIN+SIZE and dy_neg=0 if moving up and candidate Y-SIZE <= Y_MIN.
REQ-035 Paddle: when moving down, candidate Y+SIZE >= PADDLE_Y, current BallY+SIZE < PADDLE_Y, and |candX-paddle_x| <= paddle_hw+SIZE, SHALL set BallY=PADDLE_Y-SIZE and dy_neg=1.
REQ-036 Paddle: SHALL set dx_neg=1 if candX<paddle_x, dx_neg=0 if candX>paddle_x, and leave dx_neg unchanged if equal.
REQ-037 SHALL increment the hit counter on each paddle hit; when it reaches HITS_PER_STEP, SHALL clear the counter and set speed=min(speed+1, STEP_MAX).
REQ-038 Miss: moving down with candidate Y+SIZE >= Y_MAX and no paddle hit SHALL clamp BallY=Y_MAX-SIZE, enter LOST and assert miss for exactly that frame.
REQ-039 Wall/paddle reflection on an axis SHALL override a brick reversal on the same axis in the same frame; a paddle hit SHALL take precedence over a miss.
REQ-040 LOST: SHALL hold BallX/BallY, ignore keycode and brick_hit, count LOST_FRAMES frames, then enter SERVE with speed=STEP_INIT and the hit counter cleared.
REQ-041 Encoding 11 SHALL be unreachable; if entered, SHALL go to SERVE on the next frame.

Reset
REQ-042 SHALL, while Reset=0 and independently of frame_clk, set ball_state=SERVE, BallX=START_X, BallY=PADDLE_Y-SIZE-1, speed=STEP_INIT, dx_neg=0, dy_neg=1, both counters=0 and miss=0.
REQ-043 Reset asserted in any state, including mid-LOST or mid-pause, SHALL abort the activity; the first edge after release SHALL perform SERVE tracking.

Verification
REQ-044 Reset, paddle_x=100, 2 frames -> state 00, BallX=100, BallY=455; then keycode=2C -> state 01, speed 1, BallY decreasing by 1/frame.
REQ-045 PLAY at BallX=16 moving left, speed 3 -> next frame BallX=14, dx_neg=0; following frame BallX=17 (no lag frame).
REQ-046 Ball descending over paddle_x=320, paddle_hw=20, BallX=310 -> BallY=456, dy_neg=1, dx_neg=1; 4 such hits -> speed 2; 16 hits with defaults -> speed saturates at 4.
REQ-047 Ball descending with paddle far away -> miss high for 1 frame, state 10 for 60 frames, then 00 with speed 1.
REQ-048 brick_hit=1, brick_vert=1 on the same frame as a top-wall contact -> dy_neg=0 (wall wins); hold keycode=29 -> position frozen.
REQ-049 Reset pulsed low mid-LOST between edges -> outputs take reset values immediately, miss=0.

Source files
------------

// File: rtl/breakout_ball.sv
// Breakout ball engine: serve tracking, wall/paddle/brick reflection, speed ramp and miss hold.
// Motion is kept as two direction bits plus an unsigned speed magnitude; everything updates on frame_clk.
`timescale 1ns/1ps
module breakout_ball #(
    parameter int W             = 10,
    parameter int X_MIN         = 10,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int SIZE          = 4,
    parameter int PADDLE_Y      = 460,
    parameter int START_X       = 320,
    parameter int STEP_INIT     = 1,
    parameter int STEP_MAX      = 4,
    parameter int HITS_PER_STEP = 4,
    parameter int LOST_FRAMES   = 60
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [7:0]   keycode,
    input  logic [W-1:0] paddle_x,
    input  logic [W-1:0] paddle_hw,
    input  logic         brick_hit,
    input  logic         brick_vert,
    output logic [W-1:0] BallX,
    output logic [W-1:0] BallY,
    output logic [W-1:0] BallS,
    output logic [1:0]   ball_state,
    output logic [2:0]   speed,
    output logic         miss
);
    typedef enum logic [1:0] {ST_SERVE = 2'b00, ST_PLAY = 2'b01, ST_LOST = 2'b10} state_t;

    localparam int SW  = W + 2;
    localparam int HCW = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
    localparam int LCW = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
    typedef logic signed [SW-1:0] coord_t;

    localparam coord_t C_XMIN = coord_t'(X_MIN);
    localparam coord_t C_XMAX = coord_t'(X_MAX);
    localparam coord_t C_YMIN = coord_t'(Y_MIN);
    localparam coord_t C_YMAX = coord_t'(Y_MAX);
    localparam coord_t C_PADY = coord_t'(PADDLE_Y);
    localparam coord_t C_SIZE = coord_t'(SIZE);

    localparam logic [W-1:0]   X_LO      = W'(X_MIN + SIZE);
    localparam logic [W-1:0]   X_HI      = W'(X_MAX - SIZE);
    localparam logic [W-1:0]   X_START   = W'(START_X);
    localparam logic [W-1:0]   Y_SERVE   = W'(PADDLE_Y - SIZE - 1);
    localparam logic [W-1:0]   Y_TOP     = W'(Y_MIN + SIZE);
    localparam logic [W-1:0]   Y_PAD     = W'(PADDLE_Y - SIZE);
    localparam logic [W-1:0]   Y_LOW     = W'(Y_MAX - SIZE);
    localparam logic [2:0]     SPD_INIT  = 3'(STEP_INIT);
    localparam logic [2:0]     SPD_MAX   = 3'(STEP_MAX);
    localparam logic [HCW-1:0] HIT_LAST  = HCW'(HITS_PER_STEP - 1);
    localparam logic [LCW-1:0] LOST_LAST = LCW'(LOST_FRAMES - 1);
    localparam logic [7:0]     KEY_SERVE = 8'h2C;
    localparam logic [7:0]     KEY_PAUSE = 8'h29;

    state_t         r_state,  w_state_nxt;
    logic [W-1:0]   r_x,      w_x_nxt;
    logic [W-1:0]   r_y,      w_y_nxt;
    logic           r_dx_neg, w_dx_nxt;
    logic           r_dy_neg, w_dy_nxt;
    logic [2:0]     r_speed,  w_speed_nxt;
    logic [HCW-1:0] r_hits,   w_hits_nxt;
    logic [LCW-1:0] r_lost,   w_lost_nxt;
    logic           r_miss,   w_miss_nxt;

    logic   w_dx_b, w_dy_b;
    coord_t w_step, w_cx, w_cy, w_dist, w_adist;
    logic   w_hit_left, w_hit_right, w_hit_top, w_hit_pad, w_hit_miss;

    // Brick reversal is applied before stepping, so the candidate already moves the new way.
    assign w_dx_b  = r_dx_neg ^ (brick_hit & ~brick_vert);
    assign w_dy_b  = r_dy_neg ^ (brick_hit & brick_vert);
    assign w_step  = coord_t'(r_speed);
    assign w_cx    = w_dx_b ? coord_t'(r_x) - w_step : coord_t'(r_x) + w_step;
    assign w_cy    = w_dy_b ? coord_t'(r_y) - w_step : coord_t'(r_y) + w_step;
    assign w_dist  = w_cx - coord_t'(paddle_x);
    assign w_adist = w_dist[SW-1] ? -w_dist : w_dist;

    assign w_hit_left  = w_dx_b  && (w_cx - C_SIZE <= C_XMIN);
    assign w_hit_right = !w_dx_b && (w_cx + C_SIZE >= C_XMAX);
    assign w_hit_top   = w_dy_b  && (w_cy - C_SIZE <= C_YMIN);
    assign w_hit_pad   = !w_dy_b && (w_cy + C_SIZE >= C_PADY)
                         && (coord_t'(r_y) + C_SIZE < C_PADY)
                         && (w_adist <= coord_t'(paddle_hw) + C_SIZE);
    assign w_hit_miss  = !w_dy_b && !w_hit_pad && (w_cy + C_SIZE >= C_YMAX);

    always_comb begin
        // NOTE: every next-state signal is defaulted first, so no branch can infer a latch.
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dx_nxt    = r_dx_neg;
        w_dy_nxt    = r_dy_neg;
        w_speed_nxt = r_speed;
        w_hits_nxt  = r_hits;
        w_lost_nxt  = r_lost;
        w_miss_nxt  = 1'b0;
        case (r_state)
            ST_SERVE: begin
                if (paddle_x < X_LO)      w_x_nxt = X_LO;
                else if (paddle_x > X_HI) w_x_nxt = X_HI;
                else                      w_x_nxt = paddle_x;
                w_y_nxt = Y_SERVE;
                if (keycode == KEY_SERVE) begin
                    w_state_nxt = ST_PLAY;
                    w_dx_nxt    = 1'b0;
                    w_dy_nxt    = 1'b1;
                    w_speed_nxt = SPD_INIT;
                end
            end
            ST_PLAY: begin
                if (keycode != KEY_PAUSE) begin
                    w_x_nxt  = w_cx[W-1:0];
                    w_y_nxt  = w_cy[W-1:0];
                    w_dx_nxt = w_dx_b;
                    w_dy_nxt = w_dy_b;
                    if (w_hit_pad) begin
                        if (w_dist[SW-1])     w_dx_nxt = 1'b1;
                        else if (w_dist != '0) w_dx_nxt = 1'b0;
                        w_y_nxt  = Y_PAD;
                        w_dy_nxt = 1'b1;
                        if (r_hits == HIT_LAST) begin
                            w_hits_nxt  = '0;
                            w_speed_nxt = (r_speed < SPD_MAX) ? r_speed + 3'd1 : SPD_MAX;
                        end else begin
                            w_hits_nxt = r_hits + HCW'(1);
                        end
                    end
                    // Side walls are resolved last so they also win over paddle steering.
                    if (w_hit_left) begin
                        w_x_nxt  = X_LO;
                        w_dx_nxt = 1'b0;
                    end else if (w_hit_right) begin
                        w_x_nxt  = X_HI;
                        w_dx_nxt = 1'b1;
                    end
                    if (w_hit_top) begin
                        w_y_nxt  = Y_TOP;
                        w_dy_nxt = 1'b0;
                    end
                    if (w_hit_miss) begin
                        w_y_nxt     = Y_LOW;
                        w_state_nxt = ST_LOST;
                        w_miss_nxt  = 1'b1;
                        w_lost_nxt  = '0;
                    end
                end
            end
            ST_LOST: begin
                if (r_lost == LOST_LAST) begin
                    w_state_nxt = ST_SERVE;
                    w_lost_nxt  = '0;
                    w_speed_nxt = SPD_INIT;
                    w_hits_nxt  = '0;
                end else begin
                    w_lost_nxt = r_lost + LCW'(1);
                end
            end
            default: w_state_nxt = ST_SERVE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= ST_SERVE;
            r_x      <= X_START;
            r_y      <= Y_SERVE;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b1;
            r_speed  <= SPD_INIT;
            r_hits   <= '0;
            r_lost   <= '0;
            r_miss   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_dx_neg <= w_dx_nxt;
            r_dy_neg <= w_dy_nxt;
            r_speed  <= w_speed_nxt;
            r_hits   <= w_hits_nxt;
            r_lost   <= w_lost_nxt;
            r_miss   <= w_miss_nxt;
        end
    end

    assign BallX      = r_x;
    assign BallY      = r_y;
    assign BallS      = W'(SIZE);
    assign ball_state = r_state;
    assign speed      = r_speed;
    assign miss       = r_miss;
endmodule

// File: tb/tb_breakout_ball.sv
// Self-checking bench for breakout_ball: directed scenarios plus randomized play,
// each frame compared against an integer-velocity model of the ball rules.
`timescale 1ns/1ps
module tb_breakout_ball;
    localparam int W      = 10;
    localparam int XL     = 14;
    localparam int XR     = 635;
    localparam int YT     = 4;
    localparam int YPAD   = 456;
    localparam int YSERVE = 455;
    localparam int YLOW   = 475;

    logic         frame_clk  = 1'b0;
    logic         Reset      = 1'b1;
    logic [7:0]   keycode    = 8'h00;
    logic [W-1:0] paddle_x   = '0;
    logic [W-1:0] paddle_hw  = '0;
    logic         brick_hit  = 1'b0;
    logic         brick_vert = 1'b0;
    logic [W-1:0] BallX, BallY, BallS;
    logic [1:0]   ball_state;
    logic [2:0]   speed;
    logic         miss;
    logic [25:0]  dut_vec;

    breakout_ball dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .paddle_x  (paddle_x),
        .paddle_hw (paddle_hw),
        .brick_hit (brick_hit),
        .brick_vert(brick_vert),
        .BallX     (BallX),
        .BallY     (BallY),
        .BallS     (BallS),
        .ball_state(ball_state),
        .speed     (speed),
        .miss      (miss)
    );

    always #5 frame_clk = ~frame_clk;
    assign dut_vec = {ball_state, BallX, BallY, speed, miss};

    int n_run  = 0;
    int n_fail = 0;

    // Model: state 0 serve / 1 play / 2 lost; velocity as signed unit vectors times speed.
    int m_state, m_x, m_y, m_sx, m_sy, m_speed, m_hits, m_lost, m_miss, m_pad_evt, m_pad_total;

    function automatic logic [25:0] model_vec();
        return {2'(m_state), 10'(m_x), 10'(m_y), 3'(m_speed), 1'(m_miss)};
    endfunction

    function automatic string show(logic [25:0] v);
        return $sformatf("st=%0d x=%0d y=%0d spd=%0d miss=%0d", v[25:24], v[23:14], v[13:4], v[3:1], v[0]);
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 320; m_y = YSERVE; m_sx = 1; m_sy = -1; m_speed = 1;
        m_hits = 0; m_lost = 0; m_miss = 0; m_pad_evt = 0; m_pad_total = 0;
    endtask

    task automatic model_frame();
        int px, hw, nx, ny, sy0, d;
        bit pad, left, right;
        px = int'(paddle_x);
        hw = int'(paddle_hw);
        m_miss = 0;
        m_pad_evt = 0;
        case (m_state)
            0: begin
                m_x = (px < XL) ? XL : (px > XR) ? XR : px;
                m_y = YSERVE;
                if (keycode == 8'h2C) begin
                    m_state = 1; m_sx = 1; m_sy = -1; m_speed = 1;
                end
            end
            1: if (keycode != 8'h29) begin
                if (brick_hit) begin
                    if (brick_vert) m_sy = -m_sy;
                    else            m_sx = -m_sx;
                end
                nx = m_x + m_sx * m_speed;
                ny = m_y + m_sy * m_speed;
                sy0 = m_sy;
                left  = (m_sx < 0) && (nx - 4 <= 10);
                right = (m_sx > 0) && (nx + 4 >= 639);
                d = nx - px;
                if (d < 0) d = -d;
                pad = (sy0 > 0) && (ny + 4 >= 460) && (m_y + 4 < 460) && (d <= hw + 4);
                if (pad) begin
                    if (nx < px)      m_sx = -1;
                    else if (nx > px) m_sx = 1;
                    ny = YPAD; m_sy = -1; m_pad_evt = 1; m_pad_total++;
                    m_hits++;
                    if (m_hits == 4) begin
                        m_hits = 0;
                        if (m_speed < 4) m_speed++;
                    end
                end
                if (left) begin nx = XL; m_sx = 1; end
                else if (right) begin nx = XR; m_sx = -1; end
                if (sy0 < 0 && ny - 4 <= 0) begin ny = YT; m_sy = 1; end
                if (sy0 > 0 && !pad && ny + 4 >= 479) begin
                    ny = YLOW; m_state = 2; m_miss = 1; m_lost = 0;
                end
                m_x = nx;
                m_y = ny;
            end
            2: begin
                m_lost++;
                if (m_lost == 60) begin
                    m_state = 0; m_speed = 1; m_hits = 0; m_lost = 0;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic tick();
        model_frame();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        keycode = 8'h00; brick_hit = 1'b0;
        #2 Reset = 1'b0;
        model_reset();
        #4 Reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        model_reset();
        #2;
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_async: got %s want %s", show(dut_vec), show(model_vec()));
        end
        n_run++;
        if (BallS !== 10'd4) begin
            n_fail++; $display("FAIL ball_size: got %0d want 4", BallS);
        end
        @(posedge frame_clk); #1;
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_held: got %s want %s", show(dut_vec), show(model_vec()));
        end
        #2 Reset = 1'b1;
    endtask

    task automatic test_serve();
        paddle_x = 10'd100; paddle_hw = 10'd20;
        tick(); tick();
        n_run++;
        if (dut_vec !== model_vec() || BallX !== 10'd100 || BallY !== 10'd455 || ball_state !== 2'b00) begin
            n_fail++; $display("FAIL serve_track: got %s want st=0 x=100 y=455", show(dut_vec));
        end
        paddle_x = 10'd3; tick();
        n_run++;
        if (BallX !== 10'd14) begin
            n_fail++; $display("FAIL serve_clamp_lo: got %0d want 14", BallX);
        end
        paddle_x = 10'd900; tick();
        n_run++;
        if (BallX !== 10'd635) begin
            n_fail++; $display("FAIL serve_clamp_hi: got %0d want 635", BallX);
        end
        paddle_x = 10'd100; tick();
        keycode = 8'h2C; tick();
        n_run++;
        if (dut_vec !== model_vec() || ball_state !== 2'b01 || speed !== 3'd1) begin
            n_fail++; $display("FAIL serve_launch: got %s want %s", show(dut_vec), show(model_vec()));
        end
        keycode = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_run++;
            if (dut_vec !== model_vec() || BallY !== 10'(YSERVE - k)) begin
                n_fail++; $display("FAIL serve_ascend: got %s want %s", show(dut_vec), show(model_vec()));
            end
        end
    endtask

    task automatic test_left_wall();
        do_reset();
        paddle_x = 10'd14; paddle_hw = 10'd20;
        tick();
        keycode = 8'h2C; tick();
        keycode = 8'h00; tick();
        n_run++;
        if (dut_vec !== model_vec() || BallX !== 10'd15) begin
            n_fail++; $display("FAIL left_setup: got %s want %s", show(dut_vec), show(model_vec()));
        end
        brick_hit = 1'b1; brick_vert = 1'b0; tick();
        brick_hit = 1'b0;
        n_run++;
        if (dut_vec !== model_vec() || BallX !== 10'd14) begin
            n_fail++; $display("FAIL left_wall_clamp: got %s want %s", show(dut_vec), show(model_vec()));
        end
        tick();
        n_run++;
        if (dut_vec !== model_vec() || BallX !== 10'd15) begin
            n_fail++; $display("FAIL left_wall_rebound: got %s want %s", show(dut_vec), show(model_vec()));
        end
    endtask

    task automatic test_top_wall_pause();
        for (int f = 0; f < 1000 && m_y > 5; f++) begin
            tick();
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL top_approach: got %s want %s", show(dut_vec), show(model_vec()));
            end
        end
        tick();
        n_run++;
        if (dut_vec !== model_vec() || BallY !== 10'd4) begin
            n_fail++; $display("FAIL top_clamp: got %s want %s", show(dut_vec), show(model_vec()));
        end
        brick_hit = 1'b1; brick_vert = 1'b1; tick();
        brick_hit = 1'b0;
        n_run++;
        if (dut_vec !== model_vec() || BallY !== 10'd4) begin
            n_fail++; $display("FAIL top_wall_wins: got %s want %s", show(dut_vec), show(model_vec()));
        end
        tick();
        n_run++;
        if (dut_vec !== model_vec() || BallY !== 10'd5) begin
            n_fail++; $display("FAIL top_rebound: got %s want %s", show(dut_vec), show(model_vec()));
        end
        keycode = 8'h29;
        for (int k = 0; k < 5; k++) begin
            brick_hit = 1'($urandom_range(1, 0));
            brick_vert = 1'($urandom_range(1, 0));
            tick();
            n_run++;
            if (dut_vec !== model_vec() || BallY !== 10'd5) begin
                n_fail++; $display("FAIL pause_hold: got %s want %s", show(dut_vec), show(model_vec()));
            end
        end
        keycode = 8'h00; brick_hit = 1'b0; tick();
        n_run++;
        if (dut_vec !== model_vec() || BallY !== 10'd6) begin
            n_fail++; $display("FAIL pause_release: got %s want %s", show(dut_vec), show(model_vec()));
        end
    endtask

    task automatic test_paddle_speed();
        paddle_hw = 10'd20;
        for (int f = 0; f < 30000 && m_pad_total < 16; f++) begin
            int px;
            px = m_x + int'($urandom_range(40, 0)) - 20;
            if (px < 0) px = 0;
            paddle_x = W'(px);
            tick();
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL paddle_track: got %s want %s", show(dut_vec), show(model_vec()));
            end
            if (m_pad_evt != 0) begin
                n_run++;
                if (BallY !== 10'd456) begin
                    n_fail++; $display("FAIL paddle_land: got y=%0d want 456", BallY);
                end
                if (m_pad_total == 4) begin
                    n_run++;
                    if (speed !== 3'd2) begin
                        n_fail++; $display("FAIL speed_after_4: got %0d want 2", speed);
                    end
                end
                if (m_pad_total == 16) begin
                    n_run++;
                    if (speed !== 3'd4) begin
                        n_fail++; $display("FAIL speed_sat_16: got %0d want 4", speed);
                    end
                end
            end
        end
        n_run++;
        if (m_pad_total < 16) begin
            n_fail++; $display("FAIL paddle_timeout: got %0d hits want 16", m_pad_total);
        end
    endtask

    task automatic test_miss();
        int lost_seen, miss_seen;
        paddle_x = 10'd0; paddle_hw = 10'd0;
        for (int f = 0; f < 3000 && m_miss == 0; f++) begin
            tick();
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL miss_approach: got %s want %s", show(dut_vec), show(model_vec()));
            end
        end
        n_run++;
        if (miss !== 1'b1 || ball_state !== 2'b10 || BallY !== 10'd475) begin
            n_fail++; $display("FAIL miss_entry: got %s want st=2 y=475 miss=1", show(dut_vec));
        end
        lost_seen = 1; miss_seen = 1;
        for (int f = 0; f < 65; f++) begin
            tick();
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL lost_hold: got %s want %s", show(dut_vec), show(model_vec()));
            end
            if (ball_state === 2'b10) lost_seen++;
            if (miss === 1'b1) miss_seen++;
        end
        n_run++;
        if (lost_seen != 60 || miss_seen != 1) begin
            n_fail++; $display("FAIL lost_duration: got lost=%0d miss=%0d want 60 and 1", lost_seen, miss_seen);
        end
        n_run++;
        if (ball_state !== 2'b00 || speed !== 3'd1) begin
            n_fail++; $display("FAIL lost_exit: got st=%0d spd=%0d want 0 and 1", ball_state, speed);
        end
    endtask

    task automatic test_reset_mid_lost();
        paddle_x = 10'd200; paddle_hw = 10'd20;
        keycode = 8'h2C; tick();
        keycode = 8'h00; paddle_x = 10'd0; paddle_hw = 10'd0;
        for (int f = 0; f < 3000 && m_miss == 0; f++) tick();
        for (int f = 0; f < 10; f++) tick();
        n_run++;
        if (dut_vec !== model_vec() || ball_state !== 2'b10) begin
            n_fail++; $display("FAIL mid_lost_setup: got %s want %s", show(dut_vec), show(model_vec()));
        end
        #3 Reset = 1'b0;
        model_reset();
        #1;
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_mid_lost: got %s want %s", show(dut_vec), show(model_vec()));
        end
        #2 Reset = 1'b1;
        paddle_x = 10'd200; tick();
        n_run++;
        if (dut_vec !== model_vec() || BallX !== 10'd200 || ball_state !== 2'b00) begin
            n_fail++; $display("FAIL post_reset_track: got %s want %s", show(dut_vec), show(model_vec()));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 4000; f++) begin
            int r, px;
            r = int'($urandom_range(99, 0));
            keycode = (r < 8) ? 8'h2C : (r < 15) ? 8'h29 : 8'h00;
            brick_hit = ($urandom_range(9, 0) == 0);
            brick_vert = 1'($urandom_range(1, 0));
            if ($urandom_range(4, 0) == 0) px = int'($urandom_range(1023, 0));
            else px = m_x + int'($urandom_range(60, 0)) - 30;
            if (px < 0) px = 0;
            if (px > 1023) px = 1023;
            paddle_x = W'(px);
            paddle_hw = W'($urandom_range(40, 0));
            tick();
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL random_frame %0d: got %s want %s", f, show(dut_vec), show(model_vec()));
            end
        end
        keycode = 8'h00; brick_hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_left_wall();
        test_top_wall_pause();
        test_paddle_speed();
        test_miss();
        test_reset_mid_lost();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
